// File: rtl/fabric_config_loader.sv
// fabric_config_loader
//   Wishbone classic slave that feeds the FABulous fabric's serial configuration
//   port. Bitstream words are pushed into a small FIFO through the DATA register
//   and shifted out MSB-first. Each data bit is interleaved with the matching bit
//   of a programmable control word, over four phases per bit:
//   SETUP, HIGH, HOLD and LOW.
//
//   Register map (byte offsets from BASE_ADR):
//     0x0 DATA      : write pushes a word into the FIFO (reads return 0)
//     0x4 CTRL/STAT : [0] EN, [1] BUSY, [2] FULL, [3] EMPTY, [4] FLUSH (write-1 pulse)
//     0x8 CTRL_WORD : control word, reset 0x0000FAB1
//     0xC COUNT     : completed-word counter; any write clears it
//
//   Ports:
//     wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//     wbs_*              : Wishbone classic slave
//     s_clk, s_data      : fabric configuration serial clock / data
//     busy               : high while a word is being shifted
//
//   COUNT_RST is the COUNT reset value. It is left at 0 in the product and only
//   changed to preload the counter near its wrap point.
module fabric_config_loader #(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DIV        = 1,
    parameter logic [15:0] COUNT_RST  = 16'h0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        s_clk,
    output logic        s_data,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, HOLD, LOW} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_q;
    logic [31:0]   sh_q, ctl_q;
    logic          s_clk_q, s_data_q, busy_q, go_q;
    logic          en_q;
    logic [31:0]   ctrl_word_q;
    logic [15:0]   count_q;
    logic          ack_q;
    logic [31:0]   dat_o_q;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        hit, acc, wr_ok, push, pop, flush, cnt_clr;
    logic        fifo_full, fifo_empty, start_ok, last_phase, last_bit, word_done;
    logic [1:0]  off;
    logic [31:0] rd_val, fifo_head;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_head  = mem[rd_ptr_q];
    assign start_ok   = en_q & ~fifo_empty;
    assign last_phase = (div_q == DIV_LAST);
    assign last_bit   = (bit_q == 5'd0);
    assign word_done  = (state_q == LOW) & last_phase & last_bit;

    // IDLE launches one cycle after go_q sees EN and data, which places the first
    // SETUP two cycles after the enabling ack. Back-to-back words skip IDLE.
    assign pop = ((state_q == IDLE) & go_q & start_ok) | (word_done & start_ok);

    assign hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign off   = wbs_adr_i[3:2];
    assign wr_ok = wbs_we_i & (wbs_sel_i == 4'b1111);
    // A DATA push into a full FIFO holds off its ack until a pop frees a slot in
    // the same cycle. Partial-select writes are never stalled because they are
    // discarded anyway.
    assign acc     = hit & ~ack_q & ~(wr_ok & (off == 2'd0) & fifo_full & ~pop);
    assign push    = acc & wr_ok & (off == 2'd0);
    assign flush   = acc & wr_ok & (off == 2'd1) & wbs_dat_i[4];
    assign cnt_clr = acc & wr_ok & (off == 2'd3);

    always_comb begin
        rd_val = '0;
        case (off)
            2'd1:    rd_val = {28'd0, fifo_empty, fifo_full, busy_q, en_q};
            2'd2:    rd_val = ctrl_word_q;
            2'd3:    rd_val = {16'd0, count_q};
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push & ~pop)      cnt_d = cnt_q + CW'(1);
        else if (pop & ~push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_o_q     <= '0;
            en_q        <= 1'b0;
            ctrl_word_q <= 32'h0000_FAB1;
        end else begin
            ack_q   <= acc;
            dat_o_q <= (acc & ~wbs_we_i) ? rd_val : '0;
            if (acc & wr_ok) begin
                case (off)
                    2'd1:    en_q        <= wbs_dat_i[0];
                    2'd2:    ctrl_word_q <= wbs_dat_i;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            // A word popped in this same cycle is already in the shift register.
            rd_ptr_q <= wr_ptr_q;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr_q] <= wbs_dat_i;
        if (pop) begin
            sh_q  <= fifo_head;
            ctl_q <= ctrl_word_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)       count_q <= COUNT_RST;
        else if (cnt_clr)   count_q <= '0;
        else if (word_done) count_q <= count_q + 16'd1;
    end

    // Outputs are registered alongside the state: each transition also sets the
    // pin levels that belong to the state being entered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            go_q     <= 1'b0;
            s_clk_q  <= 1'b0;
            s_data_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            go_q <= start_ok;
            case (state_q)
                IDLE: begin
                    s_clk_q <= 1'b0;
                    if (pop) begin
                        state_q  <= SETUP;
                        div_q    <= '0;
                        bit_q    <= 5'd31;
                        busy_q   <= 1'b1;
                        s_data_q <= fifo_head[31];
                    end
                end
                default: begin
                    if (!last_phase) begin
                        div_q <= div_q + DW'(1);
                    end else begin
                        div_q <= '0;
                        case (state_q)
                            SETUP: begin
                                state_q <= HIGH;
                                s_clk_q <= 1'b1;
                            end
                            HIGH: begin
                                state_q  <= HOLD;
                                s_data_q <= ctl_q[bit_q];
                            end
                            HOLD: begin
                                state_q <= LOW;
                                s_clk_q <= 1'b0;
                            end
                            default: begin
                                if (!last_bit) begin
                                    bit_q    <= bit_q - 5'd1;
                                    state_q  <= SETUP;
                                    s_data_q <= sh_q[bit_q - 5'd1];
                                end else if (start_ok) begin
                                    bit_q    <= 5'd31;
                                    state_q  <= SETUP;
                                    s_data_q <= fifo_head[31];
                                end else begin
                                    // s_data keeps its last level while idle.
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign s_clk     = s_clk_q;
    assign s_data    = s_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
module tb_fabric_config_loader;

    localparam logic [31:0] A1 = 32'h3000_0000;
    localparam logic [31:0] A2 = 32'h3000_0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [31:0] dat1, dat2;
    logic        ack1, ack2, sclk1, sdata1, busy1, sclk2, sdata2, busy2;

    // Instance 1: DIV=1, depth 4. Instance 2: DIV=3, COUNT preloaded to 0xFFFF.
    fabric_config_loader #(.BASE_ADR(A1), .FIFO_DEPTH(4), .DIV(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_dat_o(dat1), .wbs_ack_o(ack1), .s_clk(sclk1), .s_data(sdata1), .busy(busy1));

    fabric_config_loader #(.BASE_ADR(A2), .FIFO_DEPTH(4), .DIV(3), .COUNT_RST(16'hFFFF)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_dat_o(dat2), .wbs_ack_o(ack2), .s_clk(sclk2), .s_data(sdata2), .busy(busy2));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_nm_q[$];
    logic [63:0] ser_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int waited);
        int n;
        n = 0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack1 | ack2) && n < 3000);
        if (!(ack1 | ack2)) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: adr 0x%08h no ack after %0d cycles", a, n);
        end
        waited = n;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int w;
        bus(1'b1, a, d, 4'b1111, w);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        int w;
        rd_exp_q.push_back(e);
        rd_nm_q.push_back(nm);
        bus(1'b0, a, 32'h0, 4'b1111, w);
    endtask

    task automatic wait_idle(input logic inst2, input int maxc, input string nm);
        int n;
        n = 0;
        while ((inst2 ? busy2 : busy1) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, {31'd0, inst2 ? busy2 : busy1}, 32'd0);
    endtask

    // Read scoreboard: pops one expectation per read ack.
    initial begin
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack1 | ack2) begin
                chk("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
                if (!we) begin
                    if (rd_exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rd_unexpected: got 0x%08h expected no read", dat1 | dat2);
                    end else begin
                        chk(rd_nm_q.pop_front(), dat1 | dat2, rd_exp_q.pop_front());
                    end
                end
            end
            prev_ack = ack1 | ack2;
        end
    end

    // Serial monitor for instance 1.
    int          rise_w1 = 0, fall_w1 = 0, rises1 = 0;
    logic [31:0] dbits1, cbits1;
    initial begin
        logic prev, cont;
        int   cycn, last_rise;
        logic [63:0] e;
        prev = 1'b0; cont = 1'b0; cycn = 0; last_rise = 0;
        forever begin
            @(posedge clk); #1;
            cycn++;
            if (rst) begin
                rise_w1 = 0; fall_w1 = 0; prev = 1'b0; cont = 1'b0;
            end else begin
                if (sclk1 && !prev) begin
                    rises1++;
                    if (cont) chk("rise_spacing1", cycn - last_rise, 32'd4);
                    last_rise = cycn;
                    cont = 1'b1;
                    dbits1 = {dbits1[30:0], sdata1};
                    rise_w1++;
                end
                if (!sclk1 && prev) begin
                    cbits1 = {cbits1[30:0], sdata1};
                    fall_w1++;
                    if (fall_w1 == 32) begin
                        if (ser_q.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL ser_unexpected: got word 0x%08h expected none", dbits1);
                        end else begin
                            e = ser_q.pop_front();
                            chk("ser_data", dbits1, e[63:32]);
                            chk("ser_ctrl", cbits1, e[31:0]);
                        end
                        rise_w1 = 0; fall_w1 = 0;
                    end
                end
                if (!busy1) cont = 1'b0;
                prev = sclk1;
            end
        end
    end

    // Instance 2: rise count, rise spacing (3 cycles per phase) and first word data.
    int          rises2 = 0;
    logic [31:0] dbits2;
    initial begin
        logic prev, cont;
        int   cycn, last_rise;
        prev = 1'b0; cont = 1'b0; cycn = 0; last_rise = 0;
        forever begin
            @(posedge clk); #1;
            cycn++;
            if (!rst) begin
                if (sclk2 && !prev) begin
                    rises2++;
                    if (cont) chk("rise_spacing2", cycn - last_rise, 32'd12);
                    last_rise = cycn;
                    cont = 1'b1;
                    if (rises2 <= 32) dbits2 = {dbits2[30:0], sdata2};
                end
                if (!busy2) cont = 1'b0;
                prev = sclk2;
            end
        end
    end

    // Busy run lengths.
    int run1 = 0, last_run1 = 0, run2 = 0, last_run2 = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (busy1) run1++;
            else if (run1 != 0) begin last_run1 = run1; run1 = 0; end
            if (busy2) run2++;
            else if (run2 != 0) begin last_run2 = run2; run2 = 0; end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] words [6] = '{32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFF,
                               32'h0000_0000, 32'hC3C3_3C3C, 32'h0F0F_F0F0};
    logic [31:0] words2 [4] = '{32'hA5A5_0F0F, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    initial begin
        int w, r0, n;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack1}, 32'd0);
        chk("rst_dat", dat1, 32'd0);
        chk("rst_sclk", {31'd0, sclk1}, 32'd0);
        chk("rst_sdata", {31'd0, sdata1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        @(negedge clk) rst = 1'b0;

        rd(A1 + 4,  32'h0000_0008, "status_rst");
        rd(A1 + 8,  32'h0000_FAB1, "ctrlword_rst");
        rd(A1 + 12, 32'h0000_0000, "count_rst");
        rd(A2 + 12, 32'h0000_FFFF, "count2_preload");

        // Single word
        wr(A1 + 8, 32'h0000_FAB1);
        ser_q.push_back({32'hA500_0000, 32'h0000_FAB1});
        wr(A1, 32'hA500_0000);
        wr(A1 + 4, 32'h1);
        @(posedge clk); #1;
        chk("en_lat_t1_busy", {31'd0, busy1}, 32'd0);
        @(posedge clk); #1;
        chk("en_lat_t2_busy", {31'd0, busy1}, 32'd1);
        chk("en_lat_t2_sclk", {31'd0, sclk1}, 32'd0);
        chk("en_lat_t2_sdata", {31'd0, sdata1}, 32'd1);
        wait_idle(1'b0, 400, "single_idle");
        chk("single_period", last_run1, 32'd128);
        rd(A1 + 12, 32'h1, "single_count");
        rd(A1 + 4,  32'h9, "single_status");

        // Back-to-back with backpressure
        wr(A1 + 12, 32'h0);
        r0 = rises1;
        for (int i = 0; i < 6; i++) begin
            ser_q.push_back({words[i], 32'h0000_FAB1});
            bus(1'b1, A1, words[i], 4'b1111, w);
        end
        chk("stall6_ack", {31'd0, (w >= 90 && w <= 140)}, 32'd1);
        wait_idle(1'b0, 1200, "b2b_idle");
        chk("b2b_rises", rises1 - r0, 32'd192);
        chk("b2b_gapless", last_run1, 32'd768);
        rd(A1 + 12, 32'h6, "b2b_count");

        // EN cleared mid-word
        wr(A1 + 4, 32'h0);
        wr(A1 + 12, 32'h0);
        ser_q.push_back({32'hDEAD_BEEF, 32'h0000_FAB1});
        wr(A1, 32'hDEAD_BEEF);
        wr(A1, 32'hFFFF_FFFF);
        wr(A1 + 4, 32'h1);
        n = 0;
        while (rise_w1 < 22 && n < 1000) begin @(posedge clk); #1; n++; end
        chk("en_clr_reach_bit10", {31'd0, rise_w1 >= 22}, 32'd1);
        wr(A1 + 4, 32'h0);
        wait_idle(1'b0, 400, "en_clr_idle");
        repeat (10) @(posedge clk);
        #1;
        chk("en_clr_stays_idle", {31'd0, busy1}, 32'd0);
        rd(A1 + 4,  32'h0, "en_clr_status");
        rd(A1 + 12, 32'h1, "en_clr_count");

        // Reset mid-word (the remaining all-ones word keeps s_data high)
        wr(A1 + 8, 32'h1234_5678);
        wr(A1 + 4, 32'h1);
        n = 0;
        while (rise_w1 < 12 && n < 1000) begin @(posedge clk); #1; n++; end
        chk("rst_reach_bit20", {31'd0, rise_w1 >= 12}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_sclk", {31'd0, sclk1}, 32'd0);
        chk("rstmid_sdata", {31'd0, sdata1}, 32'd0);
        chk("rstmid_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk) rst = 1'b0;
        rd(A1 + 4,  32'h8, "rstmid_status");
        rd(A1 + 8,  32'h0000_FAB1, "rstmid_ctrlword");
        rd(A1 + 12, 32'h0, "rstmid_count");

        // Bus corner cases
        bus(1'b1, A1 + 8, 32'hDEAD_0000, 4'b0011, w);
        rd(A1 + 8, 32'h0000_FAB1, "partial_sel_ctrlword");
        rd(A1, 32'h0, "data_read_zero");
        bus(1'b1, A1, 32'h0000_1234, 4'b0001, w);
        rd(A1 + 4, 32'h8, "partial_sel_no_push");

        // DIV=3, FLUSH, COUNT wrap
        for (int i = 0; i < 4; i++) wr(A2, words2[i]);
        rd(A2 + 4, 32'h4, "div3_full");
        wr(A2 + 4, 32'h1);
        repeat (60) @(posedge clk);
        wr(A2 + 4, 32'h11);
        wait_idle(1'b1, 1000, "div3_idle");
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_more_words", {31'd0, busy2}, 32'd0);
        chk("div3_rises", rises2, 32'd32);
        chk("div3_period", last_run2, 32'd384);
        chk("div3_data", dbits2, words2[0]);
        rd(A2 + 4,  32'h9, "flush_status");
        rd(A2 + 12, 32'h0, "count_wrap");

        repeat (5) @(posedge clk);
        #1;
        chk("rd_scoreboard_drained", rd_exp_q.size(), 32'd0);
        chk("ser_scoreboard_drained", ser_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
